ram_write_buffer: RTL and testbench

// - Sits directly downstream of the RAM controller, between its w/RAMaddr/toRAM outputs and the data memory port.
// - Posts CPU writes into a small in-order FIFO and drains them to a wait-stated memory over a req/ack handshake.
// - Serves CPU reads in program order with buffered writes.
// - Asserts stall to freeze the pipeline while the buffer is full or a read is outstanding.

---
 rtl/ram_write_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_ram_write_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_write_buffer.sv
// Posted-write buffer between the RAM controller and a wait-stated req/ack data memory.
// Define RAW_FORWARD_EN to let reads hitting a buffered address complete from the FIFO.
module ram_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w,
   input  logic [AW-1:0]            addr,
   input  logic [DW-1:0]            wdata,
   input  logic                     rd_req,
   output logic                     stall,
   output logic [DW-1:0]            rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   buf_count,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_ack,
   input  logic [DW-1:0]            mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   logic [AW-1:0]     addr_q_r [DEPTH];
   logic [DW-1:0]     data_q_r [DEPTH];
   logic [PW-1:0]     head_r;
   logic [PW-1:0]     tail_r;
   logic [CW-1:0]     count_r;
   logic              w_done_r;

   logic              full_s;
   logic              pop_s;
   logic              push_s;
   logic              w_eff_s;
   logic              rd_open_s;
   logic              stall_s;
   logic              fwd_hit_s;
   logic              fwd_take_s;
   logic [DW-1:0]     fwd_data_s;

   logic              mem_req_r;
   logic              mem_we_r;
   logic [AW-1:0]     mem_addr_r;
   logic [DW-1:0]     mem_wdata_r;
   logic              req_nxt_s;
   logic              we_nxt_s;
   logic [AW-1:0]     maddr_nxt_s;
   logic [DW-1:0]     mwdata_nxt_s;

   logic [DW-1:0]     rd_data_r;
   logic              rd_valid_r;
   logic [DW-1:0]     rd_data_nxt_s;
   logic              rd_valid_nxt_s;

   // A write held during a read stall is taken once; w_done_r masks the repeats.
   assign w_eff_s    = w & ~w_done_r;
   assign full_s     = (count_r == FULL_CNT);
   assign pop_s      = (state_r == ST_WR) & mem_ack;
   assign push_s     = w_eff_s & (~full_s | pop_s);
   assign rd_open_s  = rd_req & ~rd_valid_r;
   assign stall_s    = (w_eff_s & full_s & ~pop_s) | rd_open_s;
   assign fwd_take_s = rd_open_s & fwd_hit_s & (state_r != ST_RD);

`ifdef RAW_FORWARD_EN
   // search buffered entries oldest to youngest so the youngest match wins
   always_comb begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_r) && (addr_q_r[head_r + PW'(k)] == addr)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = data_q_r[head_r + PW'(k)];
         end else begin
            fwd_hit_s  = fwd_hit_s;
            fwd_data_s = fwd_data_s;
         end
      end
   end
`else
   assign fwd_hit_s  = 1'b0;
   assign fwd_data_s = {DW{1'b0}};
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next state: buffered writes always drain before a read may go to memory
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (count_r != {CW{1'b0}}) begin
               state_nxt_s = ST_WR;
            end else if (rd_open_s & ~push_s & ~fwd_take_s) begin
               state_nxt_s = ST_RD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WR, ST_RD: begin
            if (mem_ack) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // next values of the registered memory and read-result outputs
   always_comb begin
      req_nxt_s      = mem_req_r;
      we_nxt_s       = mem_we_r;
      maddr_nxt_s    = mem_addr_r;
      mwdata_nxt_s   = mem_wdata_r;
      rd_valid_nxt_s = 1'b0;
      rd_data_nxt_s  = rd_data_r;
      case (state_r)
         ST_IDLE: begin
            if (state_nxt_s == ST_WR) begin
               req_nxt_s    = 1'b1;
               we_nxt_s     = 1'b1;
               maddr_nxt_s  = addr_q_r[head_r];
               mwdata_nxt_s = data_q_r[head_r];
            end else if (state_nxt_s == ST_RD) begin
               req_nxt_s   = 1'b1;
               we_nxt_s    = 1'b0;
               maddr_nxt_s = addr;
            end else begin
               req_nxt_s = 1'b0;
            end
         end
         ST_WR, ST_RD: begin
            if (mem_ack) begin
               req_nxt_s = 1'b0;
            end else begin
               req_nxt_s = 1'b1;
            end
         end
         default: req_nxt_s = 1'b0;
      endcase
      if ((state_r == ST_RD) && mem_ack) begin
         rd_valid_nxt_s = 1'b1;
         rd_data_nxt_s  = mem_rdata;
      end else if (fwd_take_s) begin
         rd_valid_nxt_s = 1'b1;
         rd_data_nxt_s  = fwd_data_s;
      end else begin
         rd_valid_nxt_s = 1'b0;
         rd_data_nxt_s  = rd_data_r;
      end
   end

   // FIFO storage; contents are don't-care outside the occupied window
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_q_r[tail_r] <= addr;
         data_q_r[tail_r] <= wdata;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // remembers a write already taken while the upstream is still frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_done_r <= 1'b0;
      end else if (push_s & stall_s) begin
         w_done_r <= 1'b1;
      end else if (!stall_s) begin
         w_done_r <= 1'b0;
      end
   end

   // registered memory-side and read-result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         rd_valid_r  <= 1'b0;
         rd_data_r   <= {DW{1'b0}};
      end else begin
         mem_req_r   <= req_nxt_s;
         mem_we_r    <= we_nxt_s;
         mem_addr_r  <= maddr_nxt_s;
         mem_wdata_r <= mwdata_nxt_s;
         rd_valid_r  <= rd_valid_nxt_s;
         rd_data_r   <= rd_data_nxt_s;
      end
   end

   assign stall     = stall_s;
   assign buf_count = count_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer with a queue-based reference model and bus monitor.
module tb_ram_write_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          w;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          rd_req;
   logic          stall;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [2:0]    buf_count;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   ram_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .w(w), .addr(addr), .wdata(wdata), .rd_req(rd_req),
      .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .buf_count(buf_count),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int            ack_budget = -1;
   int            ack_delay  = 0;
   logic [DW-1:0] rdata_val  = 16'h0000;

   logic [AW-1:0] mq_addr[$];
   logic [DW-1:0] mq_data[$];
   bit            rd_pending = 1'b0;
   bit            rd_fwd     = 1'b0;
   logic [AW-1:0] rd_addr_m;
   logic [DW-1:0] rd_exp;
   bit            log_we[$];
   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   int            log_cyc[$];
   int            last_req_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // memory responder: acks after ack_delay waiting cycles while budget allows
   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end else if (wait_cnt >= ack_delay && ack_budget != 0) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata_val;
            if (ack_budget > 0) ack_budget--;
            wait_cnt  = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end
   end

   // reference model and per-cycle compare
   initial begin
      bit            p_req, p_ack, p_we, pop_o, push_o, found;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_wdata;
      int            req_len, sz;
      p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; req_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mq_addr.delete(); mq_data.delete();
            rd_pending = 1'b0; p_req = 1'b0; req_len = 0;
         end else begin
            sz     = mq_addr.size();
            pop_o  = mem_req && mem_we && mem_ack;
            push_o = w && (sz < DEPTH || pop_o);
            check("buf_count", buf_count, sz);
            check("stall", stall, (w && sz == DEPTH && !pop_o) || (rd_req && !rd_valid));
            if (p_req && !p_ack) begin
               check("req_held", mem_req, 1);
               check("we_held", mem_we, p_we);
               check("addr_held", mem_addr, p_addr);
               check("wdata_held", mem_wdata, p_wdata);
            end else if (p_req && p_ack) begin
               check("req_gap", mem_req, 0);
            end
            if (mem_req && mem_we) begin
               if (sz == 0) check("wr_nonempty", 0, 1);
               else begin
                  check("wr_addr", mem_addr, mq_addr[0]);
                  check("wr_data", mem_wdata, mq_data[0]);
               end
            end
            if (mem_req && !mem_we) begin
               check("rd_order", sz, 0);
               check("rd_addr", mem_addr, rd_addr_m);
               check("rd_issue_ok", rd_pending && !rd_fwd, 1);
            end
            if (rd_valid) begin
               check("rd_valid_ok", rd_pending, 1);
               check("rd_data", rd_data, rd_exp);
               rd_pending = 1'b0;
            end else if (rd_req && !rd_pending) begin
               rd_pending = 1'b1;
               rd_addr_m  = addr;
               rd_fwd     = 1'b0;
`ifdef RAW_FORWARD_EN
               found = 1'b0;
               for (int i = sz - 1; i >= 0; i--) begin
                  if (!found && mq_addr[i] == addr) begin
                     found  = 1'b1;
                     rd_fwd = 1'b1;
                     rd_exp = mq_data[i];
                  end
               end
`endif
            end
            if (mem_req) req_len++;
            if (mem_req && mem_ack) begin
               log_we.push_back(mem_we); log_addr.push_back(mem_addr);
               log_data.push_back(mem_we ? mem_wdata : mem_rdata); log_cyc.push_back(cyc);
               last_req_len = req_len;
               req_len = 0;
               if (!mem_we) rd_exp = mem_rdata;
            end
            if (pop_o) begin
               void'(mq_addr.pop_front()); void'(mq_data.pop_front());
            end
            if (push_o) begin
               mq_addr.push_back(addr); mq_data.push_back(wdata);
            end
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
         end
      end
   end

   // all stimulus tasks start and end 1 time unit after a rising edge
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int pc);
      int n;
      logic st;
      w = 1'b1; addr = a; wdata = d; n = 0;
      do begin
         @(negedge clk);
         st = stall; pc = cyc; n++;
         @(posedge clk); #1;
      end while (st && n < 200);
      if (st) check("write_timeout", 0, 1);
      w = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic st);
      int n;
      logic v;
      rd_req = 1'b1; addr = a; n = 0; v = 1'b0;
      while (!v && n < 200) begin
         @(negedge clk);
         v = rd_valid; d = rd_data; st = stall; n++;
         if (!v) begin @(posedge clk); #1; end
      end
      if (!v) check("read_timeout", 0, 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      bit done;
      n = 0; done = 1'b0;
      while (!done && n < 500) begin
         @(negedge clk);
         done = (buf_count == 0) && !mem_req && !rd_pending && !stall;
         n++;
      end
      if (!done) check("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int            pc, nlog, nreads;
      logic [DW-1:0] d;
      logic          st;
      rst = 1'b1; w = 1'b1; addr = 16'h0010; wdata = 16'h5555; rd_req = 1'b0;

      // reset holds everything quiet even with a write strobe present
      repeat (3) begin
         @(negedge clk);
         check("rst_count", buf_count, 0);
         check("rst_req", mem_req, 0);
         check("rst_valid", rd_valid, 0);
         check("rst_addr", mem_addr, 0);
      end
      check("rst_we", mem_we, 0);
      check("rst_rdata", rd_data, 0);
      @(posedge clk); #1;
      w = 1'b0; rst = 1'b0;

      // fill with acks held off, then one ack lets the fifth write in
      ack_budget = 0;
      for (int i = 0; i < 4; i++) do_write(16'h0100 + 16'(i), 16'hA000 + 16'(i), pc);
      @(negedge clk);
      check("count_full", buf_count, 4);
      @(posedge clk); #1;
      w = 1'b1; addr = 16'h0104; wdata = 16'hA004;
      @(negedge clk);
      check("stall_full", stall, 1);
      check("head_addr", mem_addr, 16'h0100);
      ack_budget = 1;
      @(negedge clk);
      check("stall_pop", stall, 0);
      @(posedge clk); #1;
      w = 1'b0;
      @(negedge clk);
      check("count_swap", buf_count, 4);
      check("first_addr", log_addr[0], 16'h0100);
      check("first_data", log_data[0], 16'hA000);
      ack_budget = -1;
      @(posedge clk); #1;
      wait_idle();
      check("drain_total", log_we.size(), 5);
      check("last_addr", log_addr[4], 16'h0104);
      check("last_data", log_data[4], 16'hA004);

      // write then read: write reaches memory first, read returns memory data
      rdata_val = 16'hBEEF;
      nlog = log_we.size();
      do_write(16'h0200, 16'h1234, pc);
      do_read(16'h0300, d, st);
      check("rd_beef", d, 16'hBEEF);
      check("rd_stall_drop", st, 0);
      check("ord_w_first", log_we[nlog], 1);
      check("ord_w_addr", log_addr[nlog], 16'h0200);
      check("ord_r_second", log_we[nlog+1], 0);
      check("ord_r_addr", log_addr[nlog+1], 16'h0300);
      check("wr_latency", log_cyc[nlog] - pc, 2);
      wait_idle();

      // slow memory: request held for four cycles
      ack_delay = 3;
      do_write(16'h0250, 16'h7777, pc);
      wait_idle();
      check("slow_len", last_req_len, 4);
      ack_delay = 0;

      // read of an address with two buffered writes
      ack_budget = 0;
      do_write(16'h0400, 16'h1111, pc);
      do_write(16'h0400, 16'h2222, pc);
      nlog = log_we.size();
      rd_req = 1'b1; addr = 16'h0400;
      @(negedge clk);
      check("raw_stall", stall, 1);
`ifdef RAW_FORWARD_EN
      @(negedge clk);
      check("fwd_valid", rd_valid, 1);
      check("fwd_data", rd_data, 16'h2222);
      @(posedge clk); #1;
      rd_req = 1'b0;
      ack_budget = -1;
      wait_idle();
      nreads = 0;
      for (int i = nlog; i < log_we.size(); i++) if (!log_we[i]) nreads++;
      check("fwd_no_memread", nreads, 0);
      check("fwd_drains", log_we.size() - nlog, 2);
`else
      @(negedge clk);
      check("nofwd_wait", rd_valid, 0);
      rdata_val = 16'h5A5A;
      ack_budget = -1;
      st = 1'b0; nreads = 0;
      while (!st && nreads < 100) begin
         @(negedge clk);
         st = rd_valid; d = rd_data; nreads++;
      end
      if (!st) check("nofwd_timeout", 0, 1);
      check("nofwd_data", d, 16'h5A5A);
      @(posedge clk); #1;
      rd_req = 1'b0;
      wait_idle();
      check("nofwd_w1", log_data[nlog], 16'h1111);
      check("nofwd_w2", log_data[nlog+1], 16'h2222);
      check("nofwd_rd", log_we[nlog+2], 0);
      check("nofwd_rd_addr", log_addr[nlog+2], 16'h0400);
`endif

      // reset during an outstanding read
      ack_budget = 0;
      rd_req = 1'b1; addr = 16'h0500;
      @(negedge clk);
      @(negedge clk);
      check("rd_outstanding", mem_req, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_drops_req", mem_req, 0);
      rd_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      ack_budget = -1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_valid", rd_valid, 0);
         check("post_rst_req", mem_req, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
